inst_encoder: RTL and testbench

- Inverse of the core's instruction decoder. Takes decoded RV32I fields and assembles the 32-bit instruction word: opcode+func7+func3 packed as `full_inst`, plus rd, rs1, rs2 and immediate.
- Tags each word with a byte address and buffers it in a 2-entry output FIFO with valid/ready on both sides.
- Used by the program loader and by the test harness to build instruction memory images from field-level descriptions.

---
 rtl/inst_encoder_if.sv | 46 ++++
 rtl/inst_encoder.sv | 223 ++++++++++++++++++++++
 tb/tb_inst_encoder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Field-level request bus and encoded-word output bus of the instruction encoder.
// The master side (loader or harness) sends field requests and takes encoded words.
// The slave side is the encoder itself.
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ERR_W  = 8
) ();

  // Address counter control
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;

  // Field request channel
  logic              in_valid;
  logic              in_ready;
  logic [16:0]       in_full_inst;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;

  // Encoded word channel
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output base_load, base_addr,
    output in_valid, in_full_inst, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready,
    output out_ready,
    input  out_valid, out_inst, out_addr, out_err, err_count
  );

  modport slave (
    input  base_load, base_addr,
    input  in_valid, in_full_inst, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready,
    input  out_ready,
    output out_valid, out_inst, out_addr, out_err, err_count
  );

endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: assembles a 32-bit instruction word from decoded fields,
// tags it with a byte address and buffers it in a 2-entry output FIFO.
// Out-of-range immediates and unknown opcodes still produce a word, flagged with err.
module inst_encoder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ERR_W  = 8
) (
  input logic            clk,
  input logic            rst_n,
  inst_encoder_if.slave  bus
);

  // Major opcodes
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [31:0] NopWord = 32'h0000_0013;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  assign op  = bus.in_full_inst[6:0];
  assign f3  = bus.in_full_inst[9:7];
  assign f7  = bus.in_full_inst[16:10];
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;

  // An immediate fits in N signed bits when all bits from N-1 upward agree.
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic [31:0] enc_inst;
  logic        enc_err;

  // Pack fields by instruction format and flag immediates that do not fit.
  always_comb begin
    enc_inst = NopWord;
    enc_err  = 1'b1;
    unique case (op)
      OpR: begin
        enc_inst = {f7, rs2, rs1, f3, rd, op};
        enc_err  = 1'b0;
      end
      OpImm, OpLoad, OpJalr, OpSystem, OpFence: begin
        // Shift amounts and their func7 arrive already placed in imm[11:0].
        enc_inst = {imm[11:0], rs1, f3, rd, op};
        enc_err  = ~fits12;
      end
      OpStore: begin
        enc_inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        enc_err  = ~fits12;
      end
      OpBranch: begin
        enc_inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        enc_err  = ~fits13 | imm[0];
      end
      OpLui, OpAuipc: begin
        enc_inst = {imm[31:12], rd, op};
        enc_err  = |imm[11:0];
      end
      OpJal: begin
        enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        enc_err  = ~fits21 | imm[0];
      end
      default: begin
        enc_inst = NopWord;
        enc_err  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic [1:0] count_q, count_d;
  logic       push;
  logic       pop;

  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (count_q != 2'd0);

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // ---------------------------------------------------------------------------
  // Address counter
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] push_addr;

  // A base load in the same cycle as a push retargets that very word.
  assign push_addr = bus.base_load ? bus.base_addr : addr_q;

  // Next counter value: advance past a pushed word, or jump to a new base.
  always_comb begin
    addr_d = addr_q;
    if (push) begin
      addr_d = push_addr + ADDR_W'(4);
    end else if (bus.base_load) begin
      addr_d = bus.base_addr;
    end
  end

  // Address counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter
  // ---------------------------------------------------------------------------
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Count erroneous pushes, sticking at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_err && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_count = err_cnt_q;

  // ---------------------------------------------------------------------------
  // Output FIFO (2 entries)
  // ---------------------------------------------------------------------------
  logic [31:0]       inst_q [2];
  logic [ADDR_W-1:0] ent_addr_q [2];
  logic              err_q [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;

  // Occupancy and pointer updates; push and pop together leave occupancy unchanged.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        inst_q[i]     <= '0;
        ent_addr_q[i] <= '0;
        err_q[i]      <= 1'b0;
      end
    end else if (push) begin
      inst_q[wr_ptr_q]     <= enc_inst;
      ent_addr_q[wr_ptr_q] <= push_addr;
      err_q[wr_ptr_q]      <= enc_err;
    end
  end

  assign bus.out_inst = inst_q[rd_ptr_q];
  assign bus.out_addr = ent_addr_q[rd_ptr_q];
  assign bus.out_err  = err_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vector table, hand-built backpressure and reset
// sequences, then randomized traffic against a scoreboard model.
module tb_inst_encoder;

  logic clk;
  logic rst_n;

  inst_encoder_if #(.ADDR_W(32), .ERR_W(8)) bus ();

  inst_encoder #(.ADDR_W(32), .ERR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [16:0] fi;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  // Reference encoder: range checks expressed as signed numeric bounds.
  function automatic void model_enc(input logic [16:0] fi, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] imm,
                                    output logic [31:0] w, output logic e);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    longint     si;
    op = fi[6:0];
    f3 = fi[9:7];
    f7 = fi[16:10];
    si = longint'($signed(imm));
    case (op)
      7'h33: begin
        w = {f7, rs2, rs1, f3, rd, op};
        e = 1'b0;
      end
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
        w = {imm[11:0], rs1, f3, rd, op};
        e = (si < -2048) || (si > 2047);
      end
      7'h23: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        e = (si < -2048) || (si > 2047);
      end
      7'h63: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e = (si < -4096) || (si > 4095) || (si % 2 != 0);
      end
      7'h37, 7'h17: begin
        w = {imm[31:12], rd, op};
        e = (imm % 32'd4096) != 0;
      end
      7'h6F: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e = (si < -1048576) || (si > 1048575) || (si % 2 != 0);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic drive_fields(input vec_t v);
    bus.in_full_inst = v.fi;
    bus.in_rd        = v.rd;
    bus.in_rs1       = v.rs1;
    bus.in_rs2       = v.rs2;
    bus.in_imm       = v.imm;
  endtask

  // Push one word into an empty FIFO, check it one cycle later, then pop it.
  task automatic send_one(input vec_t v, input logic [31:0] exp_addr, input int idx);
    @(posedge clk); #1;
    check($sformatf("v%0d_in_ready", idx), 64'(bus.in_ready), 64'd1);
    drive_fields(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check($sformatf("v%0d_out_valid", idx), 64'(bus.out_valid), 64'd1);
    check($sformatf("v%0d_out_inst", idx), 64'(bus.out_inst), 64'(v.exp_inst));
    check($sformatf("v%0d_out_err", idx), 64'(bus.out_err), 64'(v.exp_err));
    check($sformatf("v%0d_out_addr", idx), 64'(bus.out_addr), 64'(exp_addr));
    check($sformatf("v%0d_err_count", idx), 64'(bus.err_count), 64'(v.exp_cnt));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check($sformatf("v%0d_drained", idx), 64'(bus.out_valid), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[8];
  vec_t w;
  ent_t sb[$];

  logic [6:0] legal_ops[11];

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.base_load    = 1'b0;
    bus.base_addr    = '0;
    bus.in_valid     = 1'b0;
    bus.in_full_inst = '0;
    bus.in_rd        = '0;
    bus.in_rs1       = '0;
    bus.in_rs2       = '0;
    bus.in_imm       = '0;
    bus.out_ready    = 1'b0;

    //              full_inst  rd     rs1    rs2    imm            inst           err   cnt
    vecs[0] = '{17'h00033, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h0020_81B3, 1'b0, 8'd0};
    vecs[1] = '{17'h00013, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 8'd0};
    vecs[2] = '{17'h00037, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, 8'd0};
    vecs[3] = '{17'h00063, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_8463, 1'b0, 8'd0};
    vecs[4] = '{17'h00123, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_A423, 1'b0, 8'd0};
    vecs[5] = '{17'h0006F, 5'd0, 5'd0, 5'd0, 32'h0000_0003, 32'h0020_006F, 1'b1, 8'd1};
    vecs[6] = '{17'h00013, 5'd0, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0013, 1'b1, 8'd2};
    vecs[7] = '{17'h0007F, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 32'h0000_0013, 1'b1, 8'd3};

    legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_inst", 64'(bus.out_inst), 64'd0);
    check("rst_out_addr", 64'(bus.out_addr), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_err_count", 64'(bus.err_count), 64'd0);
    rst_n = 1'b1;

    // Directed vectors, sequential addresses from 0
    for (int i = 0; i < 8; i++) begin
      send_one(vecs[i], 32'(i * 4), i);
    end

    // Backpressure: three addi words, base loaded to 0x100 with the first push
    @(posedge clk); #1;
    w = vecs[1];
    w.imm = 32'd1;
    drive_fields(w);
    bus.base_load = 1'b1;
    bus.base_addr = 32'h100;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    check("bp_ready0", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.base_load = 1'b0;
    w.imm = 32'd2;
    drive_fields(w);
    check("bp_ready1", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    w.imm = 32'd3;
    drive_fields(w);
    check("bp_full", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    check("bp_held", 64'(bus.in_ready), 64'd0);
    check("bp_head0_addr", 64'(bus.out_addr), 64'h100);
    check("bp_head0_inst", 64'(bus.out_inst), 64'h0010_0093);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_head1_addr", 64'(bus.out_addr), 64'h104);
    check("bp_head1_inst", 64'(bus.out_inst), 64'h0020_0093);
    check("bp_ready_pp", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_head2_addr", 64'(bus.out_addr), 64'h108);
    check("bp_head2_inst", 64'(bus.out_inst), 64'h0030_0093);
    check("bp_head2_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Reset mid-stream with two entries buffered (one erroneous)
    drive_fields(vecs[5]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive_fields(vecs[0]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mr_full", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(bus.out_valid), 64'd0);
    check("mr_in_ready", 64'(bus.in_ready), 64'd1);
    check("mr_err_count", 64'(bus.err_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_one(vecs[0], 32'h0, 100);

    // Randomized traffic against the scoreboard
    do_reset();
    begin
      logic [31:0] m_addr;
      logic [7:0]  m_err;
      int          occ;
      ent_t        e;
      ent_t        got;
      vec_t        r;
      m_addr = '0;
      m_err  = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(posedge clk); #1;
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        bus.base_load = ($urandom_range(0, 40) == 0);
        bus.base_addr = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'h3);
        r.fi  = 17'($urandom);
        if ($urandom_range(0, 7) != 0) begin
          r.fi[6:0] = legal_ops[$urandom_range(0, 10)];
        end
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
          0: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
          1: r.imm = $urandom;
          2: r.imm = $urandom & 32'hFFFF_F000;
          default: r.imm = 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
        endcase
        drive_fields(r);
        #1;
        occ = sb.size();
        check("rnd_in_ready", 64'(bus.in_ready), 64'(occ < 2));
        check("rnd_out_valid", 64'(bus.out_valid), 64'(occ > 0));
        check("rnd_err_count", 64'(bus.err_count), 64'(m_err));
        if (occ > 0 && bus.out_ready) begin
          e = sb.pop_front();
          got.inst = bus.out_inst;
          got.addr = bus.out_addr;
          got.err  = bus.out_err;
          check("rnd_inst", 64'(got.inst), 64'(e.inst));
          check("rnd_addr", 64'(got.addr), 64'(e.addr));
          check("rnd_err", 64'(got.err), 64'(e.err));
        end
        if (bus.in_valid && occ < 2) begin
          model_enc(r.fi, r.rd, r.rs1, r.rs2, r.imm, e.inst, e.err);
          e.addr = bus.base_load ? bus.base_addr : m_addr;
          m_addr = e.addr + 32'd4;
          if (e.err && m_err != 8'hFF) m_err = m_err + 8'd1;
          sb.push_back(e);
        end else if (bus.base_load) begin
          m_addr = bus.base_addr;
        end
      end
    end

    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.base_load = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
